// File: rtl/gray_counter.sv
// Up/down counter holding binary state with registered binary and Gray views, Gray-coded load and terminal count.
// Define GRAY_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module gray_counter #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_d;
    logic             tc_d;
    logic             load_err_d;

    // Binary bit i is the XOR of every Gray bit from i up to the MSB.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(load_gray >> i);
        end
    end

    always_comb begin
        bin_d      = bin_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_bin > MAX_V) begin
                bin_d      = MAX_V;
                load_err_d = 1'b1;
            end else begin
                bin_d = load_bin;
            end
        end else if (en) begin
            if (up_dn) begin
                if (bin_q == MAX_V) begin
                    tc_d = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
                    bin_d = MAX_V;
`else
                    bin_d = '0;
`endif
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end else begin
                if (bin_q == '0) begin
                    tc_d = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
                    bin_d = '0;
`else
                    bin_d = MAX_V;
`endif
                end else begin
                    bin_d = bin_q - 1'b1;
                end
            end
        end
    end

    // Gray is encoded from the next binary value so both views come straight off flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q    <= '0;
            gray_q   <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= bin_d ^ (bin_d >> 1);
            tc       <= tc_d;
            load_err <= load_err_d;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: full-range (MAX=15) and MAX=9 instances share stimulus and are
// checked every cycle against an arithmetic reference model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_gray = 4'd0;

    logic [3:0] bin_a, gray_a, bin_b, gray_b;
    logic       tc_a, le_a, tc_b, le_b;

    int total = 0;
    int bad   = 0;
    int ma = 0, mb = 0;
    int prev_ga = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4)) u_full (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .bin_q(bin_a), .gray_q(gray_a), .tc(tc_a), .load_err(le_a)
    );

    gray_counter #(.WIDTH(4), .MAX_COUNT(9)) u_m9 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .bin_q(bin_b), .gray_q(gray_b), .tc(tc_b), .load_err(le_b)
    );

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Decode Gray by searching for the binary value that encodes to it.
    function automatic int g2b(input int g);
        for (int v = 0; v < 16; v++) if (to_gray(v) == g) return v;
        return -1;
    endfunction

    function automatic void model(input int cur, input int mx, input bit r, input bit e,
                                  input bit u, input bit l, input int lg,
                                  output int nxt, output bit t, output bit le);
        nxt = cur; t = 1'b0; le = 1'b0;
        if (!r) begin
            nxt = 0;
        end else if (l) begin
            int b;
            b = g2b(lg);
            if (b > mx) begin nxt = mx; le = 1'b1; end
            else nxt = b;
        end else if (e) begin
            if (u) begin
                if (cur == mx) begin
                    t = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
                    nxt = mx;
`else
                    nxt = 0;
`endif
                end else nxt = cur + 1;
            end else begin
                if (cur == 0) begin
                    t = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
                    nxt = 0;
`else
                    nxt = mx;
`endif
                end else nxt = cur - 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit u, input bit l, input logic [3:0] lg);
        int na, nb;
        bit ta, tb, la, lb;
        rst_n = r; en = e; up_dn = u; load = l; load_gray = lg;
        model(ma, 15, r, e, u, l, int'(lg), na, ta, la);
        model(mb, 9,  r, e, u, l, int'(lg), nb, tb, lb);
        @(posedge clk);
        #1;
        chk("full.bin",  int'(bin_a),  na);
        chk("full.gray", int'(gray_a), to_gray(na));
        chk("full.tc",   int'(tc_a),   int'(ta));
        chk("full.lerr", int'(le_a),   int'(la));
        chk("m9.bin",    int'(bin_b),  nb);
        chk("m9.gray",   int'(gray_b), to_gray(nb));
        chk("m9.tc",     int'(tc_b),   int'(tb));
        chk("m9.lerr",   int'(le_b),   int'(lb));
        // Every count change on the full-range instance moves exactly one Gray bit.
        if (r && !l && na != ma)
            chk("full.onebit", $countones(4'(gray_a) ^ 4'(prev_ga)), 1);
        prev_ga = int'(gray_a);
        ma = na; mb = nb;
    endtask

    initial begin
        // Reset with enable high for two cycles
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("reset.bin", int'(bin_a), 0);

        // Sixteen increments: full instance runs 1..15,0
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("up16.bin", int'(bin_a), 0);

        // Decrement from 0
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
`ifndef GRAY_COUNTER_SAT_EN
        chk("dnwrap.gray", int'(gray_a), 8);
`endif
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Gray load overrides a count request
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b1100);
        chk("load.bin", int'(bin_a), 8);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("m9.wrap.tc", int'(tc_b), 1);

        // Out-of-range load on the MAX=9 instance, then a hold cycle
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111);
        chk("m9.lerr.hi", int'(le_b), 1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

        // Alternating direction at the top bound
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'(i & 1), 1'b0, 4'd0);

        // Mid-operation reset with load and enable asserted
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'b0111);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
        chk("midrst.bin", int'(bin_a), 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised up/down counter that holds its state in binary and presents registered binary and Gray-code views of the same count every cycle. It accepts a Gray-coded load value, converting it to binary internally. Its intended role is a pointer/position source for clock-domain-crossing FIFOs and rotary/position interfaces, where a single-bit-change output is required. It generalises the combinational binary/Gray conversion of Day 01 into a stateful block with direction control, a programmable wrap point and a terminal-count flag.

## Interface
- WIDTH, 4: counter width in bits, minimum 2.
- MAX_COUNT, 2**WIDTH-1: highest count value. Must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  load request; overrides en.
- load_gray  input  WIDTH  Gray-coded load value, sampled when load=1.
- bin_q  output  WIDTH  registered count, binary.
- gray_q  output  WIDTH  registered count, Gray: bin_q ^ (bin_q >> 1).
- tc  output  1  registered one-cycle terminal-count pulse.
- load_err  output  1  registered one-cycle pulse: the loaded value exceeded MAX_COUNT.

## Operation
- Reset (rst_n=0 at a rising edge): bin_q=0, gray_q=0, tc=0, load_err=0. Reset overrides load and en.
- Priority per cycle is reset, then load, then en, then hold.
- Load:
  - Convert load_gray to binary by cascaded XOR from the MSB down.
  - If the converted value is <= MAX_COUNT, the count becomes that value and load_err=0.
  - If it is > MAX_COUNT, the count becomes MAX_COUNT and load_err=1.
  - tc=0 on any load cycle.
- Count up (en=1, up_dn=1):
  - If count < MAX_COUNT, count+1.
  - If count == MAX_COUNT, wrap to 0 and tc=1.
- Count down (en=1, up_dn=0):
  - If count > 0, count-1.
  - If count == 0, wrap to MAX_COUNT and tc=1.
- Hold (en=0, load=0): count unchanged; tc=0, load_err=0.
- gray_q is computed from the next binary value and registered alongside bin_q. It is never derived combinationally from the bin_q flop outputs, so there is no output glitch.
- Single-bit-change guarantee: between consecutive cycles, gray_q differs in exactly one bit for every non-wrap step. On wraps it holds only when MAX_COUNT = 2**WIDTH-1. For other MAX_COUNT values the wrap may change multiple bits; this is documented and permitted.
- Direction may change on any cycle with no dead cycle.

## Timing
- All outputs are registered; latency is 1 cycle from the sampling edge to the output update.
- A load sampled at edge k is visible on bin_q, gray_q and load_err after edge k.
- tc is asserted in the same cycle the wrapped value appears on bin_q/gray_q. It lasts exactly one cycle unless the next step wraps again (e.g. alternating direction at a bound).
- Reset asserted mid-count takes effect at the next edge; partial state is discarded.

## Configuration
- Macro: GRAY_COUNTER_SAT_EN.
- Undefined (default): wrap-around behaviour as specified above.
- Defined: the counter saturates instead of wrapping.
  - Up at MAX_COUNT holds at MAX_COUNT; down at 0 holds at 0.
  - tc pulses for each cycle a step is blocked at a bound.
  - Load and load_err behaviour is unchanged.

## Test plan
- Reset then count: rst_n=0 for 2 cycles with en=1 → bin_q=0, gray_q=0, tc=0. Release; en=1, up_dn=1 for 16 cycles (WIDTH=4) → bin_q runs 1..15,0. gray_q changes exactly one bit every cycle. tc=1 only on the cycle bin_q returns to 0.
- Down wrap: from bin_q=0, en=1, up_dn=0 → bin_q=15, gray_q=4'b1000, tc=1. Next cycle → bin_q=14, gray_q=4'b1001, tc=0.
- Gray load: load=1, load_gray=4'b1100, en=1, up_dn=1 → bin_q=8, gray_q=4'b1100, tc=0, load_err=0. The load overrides the count.
- Non-power-of-two wrap, MAX_COUNT=9:
  - Count up from 8 → 9, then 0 with tc=1.
  - Load load_gray=4'b1111 (binary 10) → bin_q=9, load_err=1 for one cycle.
- Mid-operation reset: count to 5, assert rst_n=0 with en=1 and load=1 → bin_q=0 after one edge.
- With GRAY_COUNTER_SAT_EN defined, WIDTH=4: hold up_dn=1 at bin_q=15 for 3 cycles → bin_q stays 15 and tc=1 on each of those cycles. Decrement at 0 → stays 0 with tc=1.
